card_shoe: RTL and testbench

- Finite card shoe that deals without replacement to the game FSM. It replaces the free-running replacement-draw RNG feeding blackjack_fsm's card_value.
- Tracks the remaining count per rank (1..13) across NUM_DECKS decks and picks a pseudo-random rank on each draw request.
- Returns the rank and its blackjack value over a request/valid handshake, and reports shoe depletion.

---
 rtl/card_pkg.sv | 40 ++++
 rtl/card_lfsr.sv | 31 +++
 rtl/card_shoe.sv | 173 +++++++++++++++++
 tb/tb_card_shoe.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/card_pkg.sv
// Shared types, constants and helpers for the card shoe dealer.
package card_pkg;

    localparam int unsigned RANK_W    = 4;
    localparam int unsigned CNT_W     = 5;
    localparam int unsigned LEFT_W    = 8;
    localparam int unsigned LFSR_W    = 16;
    localparam int unsigned CNT_SLOTS = 16;
    localparam int unsigned NUM_RANKS = 13;

    localparam logic [RANK_W-1:0] RANK_ACE  = 4'd1;
    localparam logic [RANK_W-1:0] RANK_KING = 4'd13;

    typedef enum logic {
        IDLE   = 1'b0,
        SEARCH = 1'b1
    } state_e;

    typedef struct packed {
        logic [RANK_W-1:0] rank;
        logic [RANK_W-1:0] value;
    } card_t;

    // Face cards count as ten; ace and pips count as their rank.
    function automatic logic [RANK_W-1:0] rank_to_value(input logic [RANK_W-1:0] rank);
        if (rank > 4'd10) begin
            return 4'd10;
        end
        return rank;
    endfunction

    // Folds a random nibble onto 1..13; ranks 1..3 are slightly favoured.
    function automatic logic [RANK_W-1:0] start_index(input logic [RANK_W-1:0] v);
        if (v < 4'd13) begin
            return v + 4'd1;
        end
        return v - 4'd12;
    endfunction

endpackage

// File: rtl/card_lfsr.sv
// Free-running 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1.
module card_lfsr
    import card_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] lfsr
);

    localparam logic [LFSR_W-1:0] TAPS = 16'hB400;

    logic [LFSR_W-1:0] w_lfsr_nxt;

    always_comb begin
        w_lfsr_nxt = {1'b0, lfsr[LFSR_W-1:1]};
        if (lfsr[0]) begin
            w_lfsr_nxt = w_lfsr_nxt ^ TAPS;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= SEED;
        end else begin
            lfsr <= w_lfsr_nxt;
        end
    end

endmodule

// File: rtl/card_shoe.sv
// Finite multi-deck card shoe: deals ranks without replacement over a req/valid handshake.
// Optional cut-card indicator enabled by defining CARD_SHOE_CUT_CARD_EN.
module card_shoe
    import card_pkg::*;
#(
    parameter int unsigned NUM_DECKS = 1,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int unsigned CUT_LEVEL = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       shuffle_req,
    input  logic       draw_req,
    output logic       draw_ready,
    output logic       card_valid,
    output logic [3:0] card_rank,
    output logic [3:0] card_value,
    output logic [7:0] cards_left,
    output logic       shoe_empty,
    output logic       draw_error,
    output logic       needs_shuffle
);

    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(4 * NUM_DECKS);
    localparam logic [LEFT_W-1:0] FULL_LEFT = LEFT_W'(52 * NUM_DECKS);

    generate
        if ((NUM_DECKS < 1) || (NUM_DECKS > 4) || (LFSR_SEED == 16'h0000) ||
            (CUT_LEVEL > 52 * NUM_DECKS)) begin : g_bad_params
            $error("card_shoe: illegal parameter set");
        end
    endgenerate

    state_e             r_state;
    state_e             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt     [CNT_SLOTS];
    logic [CNT_W-1:0]   w_cnt_nxt [CNT_SLOTS];
    logic [LEFT_W-1:0]  r_left;
    logic [LEFT_W-1:0]  w_left_nxt;
    logic [LEFT_W-1:0]  w_left_dec;
    logic [RANK_W-1:0]  r_probe;
    logic [RANK_W-1:0]  w_probe_nxt;
    card_t              r_card;
    card_t              w_card_nxt;
    logic               r_card_valid;
    logic               w_card_valid_nxt;
    logic               r_draw_error;
    logic               w_draw_error_nxt;
    logic               w_hit;
    logic [LFSR_W-1:0]  w_lfsr;
    logic               w_unused_lfsr;
`ifdef CARD_SHOE_CUT_CARD_EN
    logic               r_needs_shuffle;
    logic               w_needs_shuffle_nxt;
`endif

    card_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .lfsr  (w_lfsr)
    );

    // Only the low nibble seeds the probe; the rest just keeps the sequence long.
    assign w_unused_lfsr = ^w_lfsr[LFSR_W-1:RANK_W];

    // Next-state, count update and output decode.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_left_nxt       = r_left;
        w_probe_nxt      = r_probe;
        w_card_nxt       = r_card;
        w_card_valid_nxt = 1'b0;
        w_draw_error_nxt = 1'b0;
        w_hit            = (r_cnt[r_probe] != '0);
        w_left_dec       = r_left - LEFT_W'(1);
`ifdef CARD_SHOE_CUT_CARD_EN
        w_needs_shuffle_nxt = r_needs_shuffle;
`endif

        if (shuffle_req) begin
            for (int unsigned i = 0; i < CNT_SLOTS; i++) begin
                w_cnt_nxt[i] = ((i >= 1) && (i <= NUM_RANKS)) ? FULL_CNT : '0;
            end
            w_left_nxt  = FULL_LEFT;
            w_state_nxt = IDLE;
`ifdef CARD_SHOE_CUT_CARD_EN
            w_needs_shuffle_nxt = 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (draw_req) begin
                        if (r_left != '0) begin
                            w_probe_nxt = start_index(w_lfsr[RANK_W-1:0]);
                            w_state_nxt = SEARCH;
                        end else begin
                            w_draw_error_nxt = 1'b1;
                        end
                    end
                end
                SEARCH: begin
                    if (w_hit) begin
                        w_cnt_nxt[r_probe] = r_cnt[r_probe] - CNT_W'(1);
                        w_left_nxt         = w_left_dec;
                        w_card_nxt.rank    = r_probe;
                        w_card_nxt.value   = rank_to_value(r_probe);
                        w_card_valid_nxt   = 1'b1;
                        w_state_nxt        = IDLE;
`ifdef CARD_SHOE_CUT_CARD_EN
                        if (w_left_dec < LEFT_W'(CUT_LEVEL)) begin
                            w_needs_shuffle_nxt = 1'b1;
                        end
`endif
                    end else begin
                        w_probe_nxt = (r_probe == RANK_KING) ? RANK_ACE : r_probe + 4'd1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            for (int unsigned i = 0; i < CNT_SLOTS; i++) begin
                r_cnt[i] <= ((i >= 1) && (i <= NUM_RANKS)) ? FULL_CNT : '0;
            end
            r_left       <= FULL_LEFT;
            r_probe      <= RANK_ACE;
            r_card       <= '0;
            r_card_valid <= 1'b0;
            r_draw_error <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_left       <= w_left_nxt;
            r_probe      <= w_probe_nxt;
            r_card       <= w_card_nxt;
            r_card_valid <= w_card_valid_nxt;
            r_draw_error <= w_draw_error_nxt;
        end
    end

`ifdef CARD_SHOE_CUT_CARD_EN
    // Sticky until the shoe is refilled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_needs_shuffle <= 1'b0;
        end else begin
            r_needs_shuffle <= w_needs_shuffle_nxt;
        end
    end

    assign needs_shuffle = r_needs_shuffle;
`else
    assign needs_shuffle = 1'b0;
`endif

    assign draw_ready = (r_state == IDLE);
    assign card_valid = r_card_valid;
    assign card_rank  = r_card.rank;
    assign card_value = r_card.value;
    assign cards_left = r_left;
    assign shoe_empty = (r_left == '0);
    assign draw_error = r_draw_error;

endmodule

// File: tb/tb_card_shoe.sv
// Self-checking bench for card_shoe: random-timed deals against a shoe model with its own LFSR.
module tb_card_shoe;

    localparam int          ND   = 1;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int          CUT  = 15;
`ifdef CARD_SHOE_CUT_CARD_EN
    localparam bit CUT_EN = 1'b1;
`else
    localparam bit CUT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       shuffle_req = 1'b0;
    logic       draw_req = 1'b0;
    logic       draw_ready, card_valid, shoe_empty, draw_error, needs_shuffle;
    logic [3:0] card_rank, card_value;
    logic [7:0] cards_left;

    int checks = 0;
    int failures = 0;

    int          m_cnt [1:13];
    int          m_left;
    bit          m_ns;
    logic [15:0] m_lfsr;

    card_shoe #(
        .NUM_DECKS (ND),
        .LFSR_SEED (SEED),
        .CUT_LEVEL (CUT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .shuffle_req   (shuffle_req),
        .draw_req      (draw_req),
        .draw_ready    (draw_ready),
        .card_valid    (card_valid),
        .card_rank     (card_rank),
        .card_value    (card_value),
        .cards_left    (cards_left),
        .shoe_empty    (shoe_empty),
        .draw_error    (draw_error),
        .needs_shuffle (needs_shuffle)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic [15:0] t;
        t = s >> 1;
        if (s[0]) t = t ^ 16'hB400;
        return t;
    endfunction

    // Model of the random source: advances every clock like the shoe's.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= SEED;
        else        m_lfsr <= lfsr_step(m_lfsr);
    end

    function automatic int start_of(input logic [15:0] s);
        int v;
        v = int'(s[3:0]);
        return (v < 13) ? v + 1 : v - 12;
    endfunction

    function automatic int value_of(input int r);
        return (r > 10) ? 10 : r;
    endfunction

    function automatic void model_refill();
        for (int r = 1; r <= 13; r++) m_cnt[r] = 4 * ND;
        m_left = 52 * ND;
        m_ns   = 1'b0;
    endfunction

    function automatic void model_deal(input int r);
        m_cnt[r]--;
        m_left--;
        if (CUT_EN && (m_left < CUT)) m_ns = 1'b1;
    endfunction

    // First rank at or after start (wrapping K->A) still in the shoe, and probes used.
    function automatic void predict(input int start, output int rank, output int probes);
        rank   = start;
        probes = 1;
        while ((m_cnt[rank] == 0) && (probes <= 13)) begin
            rank = (rank == 13) ? 1 : rank + 1;
            probes++;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one draw and wait for the card; optionally repeats draw_req into SEARCH.
    task automatic deal_one(input bit hold, output int rank, output int value,
                            output int lat, output bit tout, output logic [15:0] l0);
        l0       = m_lfsr;
        draw_req = 1'b1;
        tick();
        lat = 1;
        if (!hold) draw_req = 1'b0;
        while (!card_valid && (lat < 40)) begin
            tick();
            lat++;
            draw_req = 1'b0;
        end
        draw_req = 1'b0;
        tout  = !card_valid;
        rank  = int'(card_rank);
        value = int'(card_value);
    endtask

    task automatic wait_start(input int r, output bit ok);
        int g = 0;
        while ((start_of(m_lfsr) != r) && (g < 1000)) begin
            tick();
            g++;
        end
        ok = (start_of(m_lfsr) == r);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #23;
        rst_n = 1'b1;
        tick();
        model_refill();
        checks++; if (cards_left !== 8'(m_left)) begin failures++; $display("FAIL reset_cards_left got=%0d want=%0d", cards_left, m_left); end
        checks++; if (draw_ready !== 1'b1) begin failures++; $display("FAIL reset_draw_ready got=%b want=1", draw_ready); end
        checks++; if (shoe_empty !== 1'b0) begin failures++; $display("FAIL reset_shoe_empty got=%b want=0", shoe_empty); end
        checks++; if (card_valid !== 1'b0) begin failures++; $display("FAIL reset_card_valid got=%b want=0", card_valid); end
        checks++; if (draw_error !== 1'b0) begin failures++; $display("FAIL reset_draw_error got=%b want=0", draw_error); end
        checks++; if (needs_shuffle !== 1'b0) begin failures++; $display("FAIL reset_needs_shuffle got=%b want=0", needs_shuffle); end
        checks++; if ({card_rank, card_value} !== 8'h00) begin failures++; $display("FAIL reset_card got=%h want=00", {card_rank, card_value}); end
    endtask

    task automatic test_back_to_back();
        int seen [1:13];
        int rank, value, lat, er, ep;
        bit tout;
        logic [15:0] l0;
        for (int r = 1; r <= 13; r++) seen[r] = 0;
        for (int i = 0; i < 52 * ND; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            checks++; if (draw_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready[%0d] got=%b want=1", i, draw_ready); end
            deal_one(1'($urandom_range(0, 1)), rank, value, lat, tout, l0);
            predict(start_of(l0), er, ep);
            checks++; if (tout) begin failures++; $display("FAIL b2b_timeout[%0d] got=no card want=card", i); end
            checks++; if (rank !== er) begin failures++; $display("FAIL b2b_rank[%0d] got=%0d want=%0d", i, rank, er); end
            checks++; if (value !== value_of(er)) begin failures++; $display("FAIL b2b_value[%0d] got=%0d want=%0d", i, value, value_of(er)); end
            checks++; if (lat !== ep + 1) begin failures++; $display("FAIL b2b_latency[%0d] got=%0d want=%0d", i, lat, ep + 1); end
            model_deal(er);
            if ((rank >= 1) && (rank <= 13)) seen[rank]++;
            checks++; if (cards_left !== 8'(m_left)) begin failures++; $display("FAIL b2b_left[%0d] got=%0d want=%0d", i, cards_left, m_left); end
            tick();
            checks++; if (card_valid !== 1'b0) begin failures++; $display("FAIL b2b_valid_pulse[%0d] got=%b want=0", i, card_valid); end
            checks++; if (needs_shuffle !== m_ns) begin failures++; $display("FAIL b2b_needs_shuffle[%0d] left=%0d got=%b want=%b", i, m_left, needs_shuffle, m_ns); end
        end
        for (int r = 1; r <= 13; r++) begin
            checks++; if (seen[r] !== 4 * ND) begin failures++; $display("FAIL b2b_rank_count[%0d] got=%0d want=%0d", r, seen[r], 4 * ND); end
        end
        checks++; if (cards_left !== 8'd0) begin failures++; $display("FAIL b2b_final_left got=%0d want=0", cards_left); end
        checks++; if (shoe_empty !== 1'b1) begin failures++; $display("FAIL b2b_shoe_empty got=%b want=1", shoe_empty); end
    endtask

    task automatic test_empty_draw();
        bit bad = 1'b0;
        draw_req = 1'b1;
        tick();
        draw_req = 1'b0;
        checks++; if (draw_error !== 1'b1) begin failures++; $display("FAIL empty_draw_error got=%b want=1", draw_error); end
        checks++; if (card_valid !== 1'b0) begin failures++; $display("FAIL empty_card_valid got=%b want=0", card_valid); end
        checks++; if (draw_ready !== 1'b1) begin failures++; $display("FAIL empty_ready got=%b want=1", draw_ready); end
        tick();
        checks++; if (draw_error !== 1'b0) begin failures++; $display("FAIL empty_error_pulse got=%b want=0", draw_error); end
        repeat (16) begin
            tick();
            if (card_valid || draw_error) bad = 1'b1;
        end
        checks++; if (bad) begin failures++; $display("FAIL empty_quiet got=activity want=none"); end
        checks++; if (cards_left !== 8'd0) begin failures++; $display("FAIL empty_left got=%0d want=0", cards_left); end
    endtask

    task automatic test_shuffle();
        bit bad = 1'b0;
        shuffle_req = 1'b1;
        draw_req    = 1'b1;
        tick();
        shuffle_req = 1'b0;
        draw_req    = 1'b0;
        model_refill();
        checks++; if (cards_left !== 8'(m_left)) begin failures++; $display("FAIL shuffle_left got=%0d want=%0d", cards_left, m_left); end
        checks++; if (shoe_empty !== 1'b0) begin failures++; $display("FAIL shuffle_empty got=%b want=0", shoe_empty); end
        checks++; if (draw_ready !== 1'b1) begin failures++; $display("FAIL shuffle_ready got=%b want=1", draw_ready); end
        checks++; if (draw_error !== 1'b0) begin failures++; $display("FAIL shuffle_error got=%b want=0", draw_error); end
        checks++; if (needs_shuffle !== 1'b0) begin failures++; $display("FAIL shuffle_needs_shuffle got=%b want=0", needs_shuffle); end
        repeat (16) begin
            tick();
            if (card_valid) bad = 1'b1;
        end
        checks++; if (bad) begin failures++; $display("FAIL shuffle_no_card got=card want=none"); end
    endtask

    task automatic test_wrap();
        int rank, value, lat;
        bit tout, ok;
        logic [15:0] l0;
        for (int r = 1; r <= 12; r++) begin
            while (m_cnt[r] > 0) begin
                wait_start(r, ok);
                checks++; if (!ok) begin failures++; $display("FAIL wrap_wait_start[%0d] got=timeout want=start", r); return; end
                deal_one(1'b0, rank, value, lat, tout, l0);
                checks++; if (rank !== r) begin failures++; $display("FAIL wrap_forced_rank got=%0d want=%0d", rank, r); end
                model_deal(r);
            end
        end
        checks++; if (cards_left !== 8'(4 * ND)) begin failures++; $display("FAIL wrap_left got=%0d want=%0d", cards_left, 4 * ND); end
        wait_start(1, ok);
        checks++; if (!ok) begin failures++; $display("FAIL wrap_wait_ace got=timeout want=start"); return; end
        deal_one(1'b0, rank, value, lat, tout, l0);
        model_deal(13);
        checks++; if (tout || (rank !== 13)) begin failures++; $display("FAIL wrap_rank got=%0d timeout=%b want=13", rank, tout); end
        checks++; if (value !== 10) begin failures++; $display("FAIL wrap_value got=%0d want=10", value); end
        checks++; if (lat !== 14) begin failures++; $display("FAIL wrap_latency got=%0d want=14", lat); end
        tick();
        checks++; if (needs_shuffle !== m_ns) begin failures++; $display("FAIL wrap_needs_shuffle got=%b want=%b", needs_shuffle, m_ns); end
    endtask

    task automatic test_shuffle_abort();
        bit ok;
        bit bad = 1'b0;
        wait_start(1, ok);
        checks++; if (!ok) begin failures++; $display("FAIL abort_wait_start got=timeout want=start"); return; end
        draw_req = 1'b1;
        tick();
        checks++; if (draw_ready !== 1'b0) begin failures++; $display("FAIL abort_in_search got=%b want=0", draw_ready); end
        shuffle_req = 1'b1;
        tick();
        shuffle_req = 1'b0;
        draw_req    = 1'b0;
        model_refill();
        checks++; if (draw_ready !== 1'b1) begin failures++; $display("FAIL abort_idle got=%b want=1", draw_ready); end
        checks++; if (card_valid !== 1'b0) begin failures++; $display("FAIL abort_valid got=%b want=0", card_valid); end
        checks++; if (cards_left !== 8'(m_left)) begin failures++; $display("FAIL abort_left got=%0d want=%0d", cards_left, m_left); end
        checks++; if (needs_shuffle !== 1'b0) begin failures++; $display("FAIL abort_needs_shuffle got=%b want=0", needs_shuffle); end
        repeat (16) begin
            tick();
            if (card_valid) bad = 1'b1;
        end
        checks++; if (bad) begin failures++; $display("FAIL abort_no_card got=card want=none"); end
    endtask

    task automatic test_after_shuffle();
        int rank, value, lat, er, ep;
        bit tout;
        logic [15:0] l0;
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 5)) tick();
            deal_one(1'b0, rank, value, lat, tout, l0);
            predict(start_of(l0), er, ep);
            checks++; if (tout || (rank !== er) || (lat !== ep + 1)) begin failures++; $display("FAIL post_rank[%0d] got=%0d lat=%0d want=%0d lat=%0d", i, rank, lat, er, ep + 1); end
            model_deal(er);
            checks++; if (cards_left !== 8'(m_left)) begin failures++; $display("FAIL post_left[%0d] got=%0d want=%0d", i, cards_left, m_left); end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_empty_draw();
        test_shuffle();
        test_wrap();
        test_shuffle_abort();
        test_after_shuffle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
